pri_arb_encoder: RTL and testbench
==================================

# pri_arb_encoder

Parametrised, registered priority encoder/arbiter. It reduces an N-bit request vector to the binary index and one-hot grant of one winning requester. Fixed-priority (highest index wins) or round-robin selection is chosen by parameter. The result is presented through a valid/ready handshake and is held stable under backpressure. The block sits between request-generating logic and any consumer that services one requester per transaction, and supersedes purely combinational 8:3 encoding wherever a registered, fair or flow-controlled result is needed.

## Interface
- N, 8, number of request lines; legal range 2..64; non-power-of-two allowed
- MODE, 0, 0 = fixed priority (index N-1 highest, 0 lowest); 1 = round-robin
- W (localparam, not overridable), $clog2(N), width of encoded index

- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- din  in  N  request vector, level-sensitive, sampled every rising edge
- dout  out  W  encoded index of the winning request
- dout_valid  out  1  dout/grant hold a valid winner
- dout_ready  in  1  consumer accepts the current winner
- grant  out  N  one-hot copy of the winner; exactly bit dout set when valid
- busy  out  1  high while a winner is held but not yet accepted (dout_valid & ~dout_ready)

## Operation
- State machine:
  - IDLE: dout_valid = 0.
  - HOLD: dout_valid = 1.
- IDLE, din != 0 at edge: arbitrate. Register winner into dout/grant, dout_valid = 1, go to HOLD.
- IDLE, din == 0: stay in IDLE.
- HOLD, no handshake (dout_ready = 0): dout, grant and dout_valid frozen. din changes, including deassertion of the winning bit, are ignored. A grant is never retracted.
- HOLD, handshake (dout_valid & dout_ready):
  - Update the round-robin pointer.
  - Arbitrate on din sampled in the same cycle, using the updated pointer.
  - din != 0: load the new winner and stay in HOLD (back-to-back, no bubble).
  - din == 0: go to IDLE, with dout_valid = 0 and dout = 0, grant = 0.
- Fixed mode (MODE = 0): winner is the highest set index of din. The pointer is unused.
- Round-robin mode (MODE = 1):
  - Pointer ptr (W bits) marks the highest-priority index.
  - Search order is ptr, ptr-1, …, 0, N-1, …, ptr+1.
  - After granting k: ptr = k-1, wrapping 0 → N-1.
  - Reset ptr = N-1, so the first arbitration matches fixed mode.
- Non-power-of-two N: ptr and dout never exceed N-1. Wrap is to N-1, not 2^W-1.
- dout and grant are 0 whenever dout_valid = 0. There are no X outputs for an empty request vector.

## Timing
- Reset (rst_n low, asynchronous): dout = 0, grant = 0, dout_valid = 0, busy = 0, ptr = N-1, state IDLE.
  - Takes effect immediately, without a clock edge.
  - A pending unaccepted winner is discarded; no handshake occurs.
- Release of rst_n is synchronous to clk. The first arbitration happens on the first rising edge with rst_n high.
- Latency: din asserted before edge t → dout_valid high after edge t (one cycle, registered).
- Throughput: one winner per cycle while dout_ready is held high and din != 0.
- dout_ready may be high while dout_valid is low; this has no effect.
- Simultaneous handshake and new requests: both are handled in the same edge (see HOLD).
- In fixed mode a still-asserted winner can win again.
- In round-robin mode, a winner that stays asserted has the lowest priority on the next arbitration.

## Test plan
1. Assert rst_n = 0 with din = 8'hFF (N = 8) for 3 cycles → dout = 0, grant = 0, dout_valid = 0 throughout. Deassert rst_n → after the first edge, dout = 7, grant = 8'h80.
2. N = 8, MODE = 0, din = 8'b0010_1100, dout_ready = 1 → one cycle later dout = 5, grant = 8'h20, dout_valid = 1. Drop din to 0 → after the handshake edge, dout_valid = 0, dout = 0.
3. Backpressure: with winner 5 held, dout_ready = 0 for 3 cycles while din changes to 8'h01 → dout stays 5 and busy = 1. Raise dout_ready → next cycle dout = 0, grant = 8'h01.
4. N = 8, MODE = 1, din = 8'hFF held, dout_ready = 1 → dout sequence 7, 6, 5, 4, 3, 2, 1, 0, 7, one per cycle, no bubbles.
5. N = 5, MODE = 1, din = 5'b10001, ready = 1 → dout alternates 4, 0, 4, 0. din = 5'b00001 → dout stays 0, ptr wraps to 4. Assert W = 3 and dout never exceeds 4.
6. Async reset mid-HOLD: winner 3 held with dout_ready = 0; pulse rst_n low between clock edges → dout_valid drops immediately. After release, ptr = N-1 and arbitration restarts from fixed order.

Source files
------------

// File: rtl/pri_arb_encoder.sv
// Registered priority encoder/arbiter: reduces a request vector to one winner
// (index + one-hot) under fixed or round-robin priority, with a valid/ready output.
module pri_arb_encoder #(
  parameter int N    = 8,
  parameter int MODE = 0,
  localparam int W   = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] din,
  output logic [W-1:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic [N-1:0] grant,
  output logic         busy
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t       state;
  logic [W-1:0] ptr;
  logic [W-1:0] ptr_adv;
  logic [W-1:0] start;
  logic         win_found;
  logic [W-1:0] win_idx;
  logic [N-1:0] win_onehot;

  // Pointer after accepting the current winner: one below it, wrapping to N-1.
  always_comb begin
    ptr_adv = (dout == '0) ? LAST : dout - 1'b1;
  end

  always_comb begin
    if (MODE == 0) begin
      start = LAST;
    end else if (state == HOLD) begin
      start = ptr_adv;
    end else begin
      start = ptr;
    end
  end

  // Search start, start-1, ..., 0, N-1, ..., start+1; first set request wins.
  always_comb begin
    logic [W-1:0] idx;
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    idx        = '0;
    for (int i = 0; i < N; i++) begin
      if (i > int'(start)) begin
        idx = start + W'(N - i);
      end else begin
        idx = start - W'(i);
      end
      if (!win_found && din[idx]) begin
        win_found       = 1'b1;
        win_idx         = idx;
        win_onehot[idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dout       <= '0;
      grant      <= '0;
      dout_valid <= 1'b0;
      ptr        <= LAST;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            dout       <= win_idx;
            grant      <= win_onehot;
            dout_valid <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (dout_ready) begin
            ptr <= ptr_adv;
            if (win_found) begin
              dout  <= win_idx;
              grant <= win_onehot;
            end else begin
              dout       <= '0;
              grant      <= '0;
              dout_valid <= 1'b0;
              state      <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = dout_valid & ~dout_ready;

endmodule

// File: tb/tb_pri_arb_encoder.sv
// Directed self-checking bench for pri_arb_encoder: fixed N=8, round-robin N=8
// and round-robin N=5 instances checked against a queue of expected results.
module tb_pri_arb_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] din0, din1, grant0, grant1;
  logic [4:0] din2, grant2;
  logic [2:0] dout0, dout1, dout2;
  logic       ready0, ready1, ready2;
  logic       valid0, valid1, valid2;
  logic       busy0, busy1, busy2;

  pri_arb_encoder #(.N(8), .MODE(0)) u_fix8 (
    .clk(clk), .rst_n(rst_n), .din(din0), .dout(dout0), .dout_valid(valid0),
    .dout_ready(ready0), .grant(grant0), .busy(busy0));

  pri_arb_encoder #(.N(8), .MODE(1)) u_rr8 (
    .clk(clk), .rst_n(rst_n), .din(din1), .dout(dout1), .dout_valid(valid1),
    .dout_ready(ready1), .grant(grant1), .busy(busy1));

  pri_arb_encoder #(.N(5), .MODE(1)) u_rr5 (
    .clk(clk), .rst_n(rst_n), .din(din2), .dout(dout2), .dout_valid(valid2),
    .dout_ready(ready2), .grant(grant2), .busy(busy2));

  typedef struct {
    int         inst;
    logic [7:0] dout;
    logic [7:0] grant;
    logic       valid;
    logic       busy;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic applyStimulus(input int inst, input logic [7:0] d, input logic r);
    case (inst)
      0: begin din0 = d;      ready0 = r; end
      1: begin din1 = d;      ready1 = r; end
      default: begin din2 = d[4:0]; ready2 = r; end
    endcase
  endtask

  task automatic expectOut(input int inst, input logic [7:0] d, input logic [7:0] g,
                           input logic v, input logic b, input string tag);
    exp_t e;
    e.inst = inst; e.dout = d; e.grant = g; e.valid = v; e.busy = b; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic compareField(input string tag, input string field,
                              input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s.%s: observed %0h, expected %0h", tag, field, obs, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t       e;
    logic [7:0] od, og;
    logic       ov, ob;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.inst)
        0: begin od = {5'b0, dout0}; og = grant0;         ov = valid0; ob = busy0; end
        1: begin od = {5'b0, dout1}; og = grant1;         ov = valid1; ob = busy1; end
        default: begin od = {5'b0, dout2}; og = {3'b0, grant2}; ov = valid2; ob = busy2; end
      endcase
      compareField(e.tag, "dout", od, e.dout);
      compareField(e.tag, "grant", og, e.grant);
      compareField(e.tag, "valid", {7'b0, ov}, {7'b0, e.valid});
      compareField(e.tag, "busy", {7'b0, ob}, {7'b0, e.busy});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 8'hFF, 1'b0);
    applyStimulus(1, 8'h00, 1'b0);
    applyStimulus(2, 8'h00, 1'b0);

    // Reset held with all requests asserted
    repeat (3) begin
      expectOut(0, 8'd0, 8'h00, 1'b0, 1'b0, "rst_hold");
      tick();
    end
    rst_n = 1'b1;
    expectOut(0, 8'd7, 8'h80, 1'b1, 1'b1, "rst_release");
    tick();

    // Fixed priority: accept 7 and pick highest of 0x2C, then drain
    applyStimulus(0, 8'h2C, 1'b1);
    expectOut(0, 8'd5, 8'h20, 1'b1, 1'b0, "fix_2c");
    tick();
    applyStimulus(0, 8'h00, 1'b1);
    expectOut(0, 8'd0, 8'h00, 1'b0, 1'b0, "fix_drain");
    tick();

    // Backpressure freezes winner 5 while din changes
    applyStimulus(0, 8'h2C, 1'b1);
    expectOut(0, 8'd5, 8'h20, 1'b1, 1'b0, "bp_load");
    tick();
    applyStimulus(0, 8'h01, 1'b0);
    repeat (3) begin
      expectOut(0, 8'd5, 8'h20, 1'b1, 1'b1, "bp_hold");
      tick();
    end
    applyStimulus(0, 8'h01, 1'b1);
    expectOut(0, 8'd0, 8'h01, 1'b1, 1'b0, "bp_release");
    tick();
    applyStimulus(0, 8'h80, 1'b1);
    expectOut(0, 8'd7, 8'h80, 1'b1, 1'b0, "fix_rewin_a");
    tick();
    expectOut(0, 8'd7, 8'h80, 1'b1, 1'b0, "fix_rewin_b");
    tick();
    applyStimulus(0, 8'h00, 1'b1);
    expectOut(0, 8'd0, 8'h00, 1'b0, 1'b0, "fix_idle");
    tick();

    // Round-robin N=8 with every request held
    applyStimulus(1, 8'hFF, 1'b1);
    for (int k = 7; k >= -1; k--) begin
      int w;
      w = (k < 0) ? 7 : k;
      expectOut(1, 8'(w), 8'(1 << w), 1'b1, 1'b0, "rr8_seq");
      tick();
    end
    applyStimulus(1, 8'h00, 1'b1);
    expectOut(1, 8'd0, 8'h00, 1'b0, 1'b0, "rr8_idle");
    tick();

    // Round-robin N=5, non-power-of-two wrap
    applyStimulus(2, 8'h11, 1'b1);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) expectOut(2, 8'd4, 8'h10, 1'b1, 1'b0, "rr5_alt");
      else            expectOut(2, 8'd0, 8'h01, 1'b1, 1'b0, "rr5_alt");
      tick();
    end
    applyStimulus(2, 8'h01, 1'b1);
    repeat (2) begin
      expectOut(2, 8'd0, 8'h01, 1'b1, 1'b0, "rr5_only0");
      tick();
    end
    applyStimulus(2, 8'h00, 1'b1);
    expectOut(2, 8'd0, 8'h00, 1'b0, 1'b0, "rr5_idle");
    tick();
    applyStimulus(2, 8'h1F, 1'b1);
    expectOut(2, 8'd4, 8'h10, 1'b1, 1'b0, "rr5_ptrwrap");
    tick();
    expectOut(2, 8'd3, 8'h08, 1'b1, 1'b0, "rr5_next");
    tick();
    applyStimulus(2, 8'h00, 1'b1);
    expectOut(2, 8'd0, 8'h00, 1'b0, 1'b0, "rr5_drain");
    tick();

    // Asynchronous reset while a round-robin winner is held
    applyStimulus(1, 8'h08, 1'b0);
    repeat (2) begin
      expectOut(1, 8'd3, 8'h08, 1'b1, 1'b1, "ar_hold");
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    expectOut(1, 8'd0, 8'h00, 1'b0, 1'b0, "ar_async");
    checkOutput();
    #1 rst_n = 1'b1;
    applyStimulus(1, 8'hFF, 1'b0);
    expectOut(1, 8'd7, 8'h80, 1'b1, 1'b1, "ar_restart");
    tick();
    applyStimulus(1, 8'hFF, 1'b1);
    expectOut(1, 8'd6, 8'h40, 1'b1, 1'b0, "ar_rr");
    tick();
    applyStimulus(1, 8'h00, 1'b1);
    expectOut(1, 8'd0, 8'h00, 1'b0, 1'b0, "ar_idle");
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
